// File: rtl/rtc_bus_defs_pkg.sv
// Shared definitions for the RTC parallel-bus sequencer:
// FSM state encoding, default timing, requester index names.
package rtc_bus_defs;

  typedef enum logic [2:0] {
    IDLE,
    A_SU,
    A_PW,
    A_H,
    D_SU,
    D_PW,
    D_H,
    REC
  } state_e;

  localparam int N_REQ     = 5;
  localparam int T_SU_DEF  = 2;
  localparam int T_PW_DEF  = 10;
  localparam int T_H_DEF   = 2;
  localparam int T_REC_DEF = 5;

  localparam int REQ_INI  = 0;
  localparam int REQ_READ = 1;
  localparam int REQ_PR   = 2;
  localparam int REQ_PF   = 3;
  localparam int REQ_PT   = 4;

  function automatic int tmax4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_rr_arbiter.sv
// Round-robin pick: first request at or after ptr_i, wrapping.
// Ports: req_i (N), ptr_i (index), gnt_o (one-hot or zero).
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  // Prefer requests at or above the pointer; else wrap to all.
  // Lowest set bit isolated with x & -x.
  always_comb begin
    hi_mask = ~((N'(1) << ptr_i) - N'(1));
    masked  = req_i & hi_mask;
    pick    = (|masked) ? masked : req_i;
    gnt_o   = pick & (~pick + N'(1));
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sole owner of the RTC bus: arbitrates N requesters and runs one
// address+data cycle per grant. Ports: clk_i, rst_i (sync, high),
// req/req_rd/req_addr/req_wdata in; gnt/done/rdata/busy out;
// cs_n/rd_n/wr_n/ad/bus_oe/bus_dout out, bus_din in.
module rtc_bus_sequencer
  import rtc_bus_defs::*;
#(
  parameter int N     = N_REQ,
  parameter int T_SU  = T_SU_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_H   = T_H_DEF,
  parameter int T_REC = T_REC_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   req_rd_i,
  input  logic [8*N-1:0] req_addr_i,
  input  logic [8*N-1:0] req_wdata_i,
  output logic [N-1:0]   gnt_o,
  output logic [N-1:0]   done_o,
  output logic [7:0]     rdata_o,
  output logic           busy_o,
  output logic           cs_n_o,
  output logic           rd_n_o,
  output logic           wr_n_o,
  output logic           ad_o,
  output logic           bus_oe_o,
  output logic [7:0]     bus_dout_o,
  input  logic [7:0]     bus_din_i
);

  if (N < 1 || T_SU < 1 || T_PW < 1 ||
      T_H < 1 || T_REC < 1) begin : g_bad_param
    $error("rtc_bus_sequencer: zero parameter");
  end

  localparam int TMAX = tmax4(T_SU, T_PW, T_H, T_REC);
  localparam int CW   = $clog2(TMAX + 1);
  localparam int PW   = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           rd_q, rd_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   done_q, done_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           busy_q, busy_d;
  logic           cs_n_q, cs_n_d;
  logic           rd_n_q, rd_n_d;
  logic           wr_n_q, wr_n_d;
  logic           ad_q, ad_d;
  logic           oe_q, oe_d;
  logic [7:0]     dout_q, dout_d;

  logic [N-1:0]   win;
  logic [PW-1:0]  win_idx;
  logic           win_rd;
  logic [7:0]     win_addr;
  logic [7:0]     win_wdata;
  logic           start;
  logic           cur_rd;
  logic [7:0]     cur_addr;
  logic [7:0]     cur_wdata;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  always_comb begin
    win_idx   = '0;
    win_rd    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        win_idx   = PW'(i);
        win_rd    = req_rd_i[i];
        win_addr  = req_addr_i[8*i +: 8];
        win_wdata = req_wdata_i[8*i +: 8];
      end
    end
  end

  assign start = (state_q == IDLE) && (|req_i);

  // Outputs are registered from the next state, so the first
  // A_SU cycle must see the winner's fields, not the latches.
  assign cur_rd    = start ? win_rd    : rd_q;
  assign cur_addr  = start ? win_addr  : addr_q;
  assign cur_wdata = start ? win_wdata : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = A_SU;
        cnt_d   = CW'(T_SU - 1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      unique case (state_q)
        A_SU: begin state_d = A_PW; cnt_d = CW'(T_PW - 1);  end
        A_PW: begin state_d = A_H;  cnt_d = CW'(T_H - 1);   end
        A_H:  begin state_d = D_SU; cnt_d = CW'(T_SU - 1);  end
        D_SU: begin state_d = D_PW; cnt_d = CW'(T_PW - 1);  end
        D_PW: begin state_d = D_H;  cnt_d = CW'(T_H - 1);   end
        D_H:  begin state_d = REC;  cnt_d = CW'(T_REC - 1); end
        default: begin state_d = IDLE; cnt_d = '0; end
      endcase
    end

    ptr_d   = ptr_q;
    rd_d    = cur_rd;
    addr_d  = cur_addr;
    wdata_d = cur_wdata;
    if (start) begin
      ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
    end

    gnt_d = gnt_q;
    if (state_d == IDLE) gnt_d = '0;
    else if (start)      gnt_d = win;

    done_d = (state_d == REC && cnt_d == '0) ? gnt_q : '0;

    rdata_d = rdata_q;
    if (state_q == D_PW && cnt_q == '0 && rd_q) rdata_d = bus_din_i;

    busy_d = (state_d != IDLE);
    cs_n_d = 1'b1;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    ad_d   = 1'b0;
    oe_d   = 1'b0;
    dout_d = '0;
    unique case (state_d)
      A_SU, A_PW, A_H: begin
        cs_n_d = 1'b0;
        oe_d   = 1'b1;
        dout_d = cur_addr;
        wr_n_d = (state_d != A_PW);
      end
      D_SU, D_PW, D_H: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b1;
        oe_d   = ~cur_rd;
        dout_d = cur_rd ? 8'h00 : cur_wdata;
        if (state_d == D_PW) begin
          rd_n_d = ~cur_rd;
          wr_n_d = cur_rd;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ad_q    <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      ad_q    <= ad_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;
  assign cs_n_o     = cs_n_q;
  assign rd_n_o     = rd_n_q;
  assign wr_n_o     = wr_n_q;
  assign ad_o       = ad_q;
  assign bus_oe_o   = oe_q;
  assign bus_dout_o = dout_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: stimulus queues expected
// transactions, a negedge monitor checks each done and bus invariants.
module tb_rtc_bus_sequencer;

  localparam int N = 5;

  typedef struct {
    int         idx;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_rd = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [7:0]     rdata;
  logic           busy;
  logic           cs_n, rd_n, wr_n, ad, bus_oe;
  logic [7:0]     bus_dout;
  logic [7:0]     bus_din = '0;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  rtc_bus_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .req_rd_i    (req_rd),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .gnt_o       (gnt),
    .done_o      (done),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .cs_n_o      (cs_n),
    .rd_n_o      (rd_n),
    .wr_n_o      (wr_n),
    .ad_o        (ad),
    .bus_oe_o    (bus_oe),
    .bus_dout_o  (bus_dout),
    .bus_din_i   (bus_din)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  name, act, exp);
  endtask

  task automatic setup(int i, logic r, logic [7:0] a,
                       logic [7:0] w);
    req_rd[i]           = r;
    req_addr[8*i +: 8]  = a;
    req_wdata[8*i +: 8] = w;
  endtask

  task automatic push(int i);
    exp_t e;
    e.idx   = i;
    e.rd    = req_rd[i];
    e.addr  = req_addr[8*i +: 8];
    e.wdata = req_wdata[8*i +: 8];
    e.rdata = bus_din;
    q.push_back(e);
  endtask

  task automatic wait_done(int i);
    int c;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done[i]) break;
    end
    if (c == 200) chk("timeout_done", 32'(i), 32'hFF);
  endtask

  task automatic wait_gnt(int i);
    int c;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (gnt[i]) break;
    end
    if (c == 200) chk("timeout_gnt", 32'(i), 32'hFF);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [N-1:0] prev_gnt;
    logic         prev_done;
    int len, wr_run, rd_len, a_len, d_len;
    logic run_ad, oe_data;
    logic [7:0] run_dout, a_dout, d_dout;
    prev_gnt = '0; prev_done = 0; len = 0; wr_run = 0;
    rd_len = 0; a_len = 0; d_len = 0; run_ad = 0;
    oe_data = 0; run_dout = 0; a_dout = 0; d_dout = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_gnt = '0; prev_done = 0; wr_run = 0; len = 0;
      end else begin
        chk("inv_rd_wr", 32'(!rd_n && !wr_n), 0);
        chk("inv_oe_rd", 32'(bus_oe && !rd_n), 0);
        chk("inv_cs", 32'((!rd_n || !wr_n) && cs_n), 0);
        chk("inv_gnt_1hot", 32'($onehot0(gnt)), 1);
        if (gnt != 0 && prev_gnt == 0) begin
          len = 0; rd_len = 0; a_len = 0; d_len = 0;
          a_dout = 0; d_dout = 0; oe_data = 0; wr_run = 0;
        end
        if (gnt != 0) len++;
        if (!wr_n) begin
          if (wr_run == 0) begin
            run_ad = ad; run_dout = bus_dout;
          end
          wr_run++;
        end else if (wr_run != 0) begin
          if (run_ad) begin d_len = wr_run; d_dout = run_dout; end
          else begin a_len = wr_run; a_dout = run_dout; end
          wr_run = 0;
        end
        if (!rd_n) rd_len++;
        if (ad && bus_oe) oe_data = 1;
        if (prev_done) begin
          chk("done_one_pulse", 32'(done), 0);
          chk("gnt_cleared", 32'(gnt), 0);
        end
        if (done != 0) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 0);
          end else begin
            e = q.pop_front();
            chk("done_idx", 32'(done), 32'(1 << e.idx));
            chk("gnt_held", 32'(gnt), 32'(1 << e.idx));
            chk("txn_len", 32'(len), 33);
            chk("addr_wr_len", 32'(a_len), 10);
            chk("addr_dout", 32'(a_dout), 32'(e.addr));
            chk("oe_in_data", 32'(oe_data), 32'(!e.rd));
            if (e.rd) begin
              chk("rd_len", 32'(rd_len), 10);
              chk("data_wr_len", 32'(d_len), 0);
              chk("rdata", 32'(rdata), 32'(e.rdata));
            end else begin
              chk("rd_len", 32'(rd_len), 0);
              chk("data_wr_len", 32'(d_len), 10);
              chk("data_dout", 32'(d_dout), 32'(e.wdata));
            end
          end
        end
        prev_gnt  = gnt;
        prev_done = (done != 0);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int order[7];
    logic r;
    int   i, c;
    order = '{0, 1, 2, 3, 4, 0, 3};

    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_rd_n", 32'(rd_n), 1);
    chk("rst_wr_n", 32'(wr_n), 1);
    chk("rst_ad", 32'(ad), 0);
    chk("rst_oe", 32'(bus_oe), 0);
    chk("rst_dout", 32'(bus_dout), 0);
    rst = 0;
    @(negedge clk);

    // Contention: all five held, reads on 1 and 3.
    for (int k = 0; k < N; k++)
      setup(k, (k == 1 || k == 3), 8'h30 + 8'(k), 8'hA0 + 8'(k));
    bus_din = 8'h5A;
    for (int k = 0; k < 7; k++) push(order[k]);
    req = 5'b11111;
    for (int k = 0; k < 5; k++) wait_done(order[k]);
    wait_gnt(0);
    req = 5'b01000;
    wait_done(0);
    wait_done(3);
    req = '0;

    // Write from requester 2.
    setup(2, 1'b0, 8'h21, 8'h45);
    push(2);
    req[2] = 1'b1;
    wait_done(2);
    req[2] = 1'b0;

    // Read from requester 1.
    setup(1, 1'b1, 8'h22, 8'h00);
    bus_din = 8'h59;
    push(1);
    req[1] = 1'b1;
    wait_done(1);
    req[1] = 1'b0;
    chk("rdata_hold", 32'(rdata), 32'h59);

    // Requester 4 drops req right after grant.
    setup(4, 1'b0, 8'h40, 8'hC3);
    push(4);
    req[4] = 1'b1;
    wait_gnt(4);
    req[4] = 1'b0;
    wait_done(4);
    repeat (4) @(negedge clk);
    chk("no_regrant", 32'(gnt), 0);

    // Reset in the 5th D_PW cycle of a write by requester 0.
    setup(0, 1'b0, 8'h10, 8'h77);
    req[0] = 1'b1;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ad && !wr_n) break;
    end
    if (c == 200) chk("timeout_dpw", 0, 1);
    repeat (4) @(negedge clk);
    rst = 1; req = '0;
    @(negedge clk);
    chk("mid_rst_cs_n", 32'(cs_n), 1);
    chk("mid_rst_wr_n", 32'(wr_n), 1);
    chk("mid_rst_oe", 32'(bus_oe), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 0;
    setup(1, 1'b0, 8'h11, 8'h88);
    push(0);
    push(1);
    req = 5'b00011;
    wait_done(0);
    req[0] = 1'b0;
    wait_done(1);
    req = '0;

    // Random mix of single reads and writes.
    for (int k = 0; k < 8; k++) begin
      i = $urandom_range(0, N - 1);
      r = 1'($urandom_range(0, 1));
      setup(i, r, 8'($urandom), 8'($urandom));
      bus_din = 8'($urandom);
      push(i);
      req[i] = 1'b1;
      wait_done(i);
      req[i] = 1'b0;
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
